clock_div_bank: RTL
===================

# clock_div_bank

Parametrised bank of independent programmable clock dividers that replaces the single fixed-rate divider. Each channel produces a divided enable-clock (`new_clk`) and a one-cycle `tick` strobe on its rising edge. The half-period can be reprogrammed at run time, and updates apply glitch-free at the next half-period boundary. A bank-wide `sync_all` phase-aligns every channel. The block sits between the system clock and the motor PWM, UART baud and sensor-sampling logic.

## Interface
- `CHANNELS`, 4: number of independent divider channels (1..16).
- `DIV_W`, 26: width of the half-period counter and programming word.
- `DEFAULT_HALF`, 26'd100000: half-period, in `clk` cycles, loaded into every channel at reset.

- `clk`  in  1: system clock; all logic is on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `en`  in  CHANNELS: per-channel run enable, level-sensitive.
- `load`  in  CHANNELS: per-channel one-cycle strobe that captures that channel's half-period slice.
- `half_in`  in  CHANNELS*DIV_W: half-period values; channel i uses bits [i*DIV_W +: DIV_W].
- `sync_all`  in  1: one-cycle strobe that restarts all channels in phase.
- `new_clk`  out  CHANNELS: divided clock per channel, registered.
- `tick`  out  CHANNELS: one-cycle pulse per channel, registered, asserted in the cycle `new_clk` goes 0→1.
- `pending`  out  CHANNELS: a loaded half-period is waiting to be applied.

## Operation
- Per-channel registers:
  - `count` (DIV_W bits)
  - `active_half` (DIV_W bits)
  - `shadow_half` (DIV_W bits)
  - `new_clk`, `tick`, `pending`
- Reset (`rst`=0, asynchronous) sets, for every channel:
  - `count`=0, `new_clk`=0, `tick`=0, `pending`=0
  - `active_half`=`shadow_half`=`DEFAULT_HALF`
- Effective half-period is H = max(`active_half`, 1). A programmed value of 0 behaves as 1, so `new_clk` toggles every cycle.
- Running (`en`=1):
  - If `count`==H-1 (wrap): `count`<=0, `new_clk`<=~`new_clk`, and `tick`<=1 when `new_clk` was 0.
  - Otherwise: `count`<=`count`+1, `tick`<=0.
- Disabled (`en`=0): `count`<=0, `new_clk`<=0, `tick`<=0 synchronously. `pending`/`shadow_half` are kept.
- `load[i]`=1: `shadow_half`<=slice i of `half_in`, `pending`<=1. A later load before application overwrites the shadow, last value wins.
- Applying a pending value (`active_half`<=`shadow_half`, `pending`<=0) happens on:
  - a wrap with `pending`=1, or
  - any cycle with `en`=0 and `pending`=1.
- `load` in the same cycle as a wrap: the wrap applies the old shadow if one was pending. The new value goes to the shadow with `pending`=1 and is applied at the next wrap.
- `sync_all`=1, for every channel:
  - `count`<=0, `new_clk`<=0, `tick`<=0
  - if `pending`, `active_half`<=`shadow_half`
  - `sync_all` has priority over wrap and counting. A `load` in the same cycle is still captured into the shadow, with `pending`=1 after the sync.
- Channels are fully independent except for `sync_all` and reset.

## Timing
- `new_clk` period is 2H cycles with exactly 50 % duty for every H≥1.
- After `en` rises (first sampled high at edge k), `new_clk` first rises at edge k+H-1 along with `tick`. The first phase is therefore H cycles, counting edge k as cycle 0.
- `tick` is high for exactly 1 cycle per `new_clk` period.
- Latency from a `load` strobe to the new rate is at most H_old cycles when `en`=1, and 1 cycle when `en`=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset mid-period abandons the period immediately, with no partial tick.

## Structure
- Package `clock_div_pkg`:
  - `DIV_W_DEFAULT`, `DEFAULT_HALF_CYCLES` (100000)
  - `MIN_HALF` (1)
  - per-channel state struct type (`count`, `active_half`, `shadow_half`, `pending`)
- Sub-module `clock_div_chan` holds one channel with parameter `DIV_W`. `clock_div_bank` instantiates `CHANNELS` copies in a generate loop and fans out `sync_all`.

## Test plan
- Reset with `DEFAULT_HALF`=4, `en`=1 → `new_clk` period 8 cycles, 4 high / 4 low; `tick` once per period, coincident with each rising edge.
- `half_in`=0 loaded while `en`=0, then enable → `new_clk` toggles every cycle, `tick` every 2nd cycle.
- H=5 running, `load` H=2 at `count`=1 → `pending`=1; old rate kept until `count`=4 wrap, then 2-cycle halves, no runt pulse; `pending`=0.
- `load` H=3 in the exact wrap cycle of a pending H=6 → H=6 applied at that wrap, H=3 applied at the following wrap.
- CHANNELS=2 with H=3 and H=7 free-running, then pulse `sync_all` → both `new_clk`=0 and `count`=0 next cycle; both rise together 3 and 7 cycles later.
- Drop `rst` mid-high-phase and release it → all outputs 0 asynchronously; `active_half` back to `DEFAULT_HALF`; `pending`=0.

Source files
------------

// File: rtl/clock_div_pkg.sv
// Shared constants and state types for the programmable clock divider bank.
// Imported by the per-channel divider and the bank top.
package clock_div_pkg;

  localparam int DIV_W_DEFAULT       = 26;
  localparam int DEFAULT_HALF_CYCLES = 100000;
  localparam int MIN_HALF            = 1;

  typedef struct packed {
    logic [DIV_W_DEFAULT-1:0] count;
    logic [DIV_W_DEFAULT-1:0] active_half;
    logic [DIV_W_DEFAULT-1:0] shadow_half;
    logic                     pending;
  } chan_state_t;

endpackage

// File: rtl/clock_div_chan.sv
// One programmable divider channel: 50% duty enable-clock, rising-edge tick,
// shadowed half-period applied only at a half-period boundary.
module clock_div_chan
  import clock_div_pkg::*;
#(
  parameter int               DIV_W    = DIV_W_DEFAULT,
  parameter logic [DIV_W-1:0] RST_HALF = DIV_W'(DEFAULT_HALF_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] half_in,
  input  logic             sync,
  output logic             new_clk,
  output logic             tick,
  output logic             pending
);

  typedef struct packed {
    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] active_half;
    logic [DIV_W-1:0] shadow_half;
    logic             pending;
  } state_t;

  state_t           st;
  logic [DIV_W-1:0] h;
  logic             wrap;
  logic             apply;

  // a programmed zero runs at the fastest rate instead of stalling
  assign h = (st.active_half < DIV_W'(MIN_HALF))
           ? DIV_W'(MIN_HALF) : st.active_half;

  assign wrap    = (st.count == h - DIV_W'(1));
  assign apply   = st.pending && (sync || !en || wrap);
  assign pending = st.pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st.count       <= '0;
      st.active_half <= RST_HALF;
      st.shadow_half <= RST_HALF;
      st.pending     <= 1'b0;
      new_clk        <= 1'b0;
      tick           <= 1'b0;
    end else begin
      if (sync || !en) begin
        st.count <= '0;
        new_clk  <= 1'b0;
        tick     <= 1'b0;
      end else if (wrap) begin
        st.count <= '0;
        new_clk  <= ~new_clk;
        tick     <= ~new_clk;
      end else begin
        st.count <= st.count + DIV_W'(1);
        tick     <= 1'b0;
      end
      if (apply) begin
        st.active_half <= st.shadow_half;
        st.pending     <= 1'b0;
      end
      // a same-cycle load wins over the clear and waits for the next boundary
      if (load) begin
        st.shadow_half <= half_in;
        st.pending     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_div_bank.sv
// Bank of independent programmable clock dividers with a shared
// phase-align strobe.
module clock_div_bank
  import clock_div_pkg::*;
#(
  parameter int               CHANNELS     = 4,
  parameter int               DIV_W        = DIV_W_DEFAULT,
  parameter logic [DIV_W-1:0] DEFAULT_HALF = DIV_W'(DEFAULT_HALF_CYCLES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*DIV_W-1:0] half_in,
  input  logic                      sync_all,
  output logic [CHANNELS-1:0]       new_clk,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       pending
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    clock_div_chan #(
      .DIV_W    (DIV_W),
      .RST_HALF (DEFAULT_HALF)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .load    (load[i]),
      .half_in (half_in[i*DIV_W +: DIV_W]),
      .sync    (sync_all),
      .new_clk (new_clk[i]),
      .tick    (tick[i]),
      .pending (pending[i])
    );
  end

endmodule
